// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end (fetch_unit, next_pc_calc, controller).
// Holds instruction field positions, the fetch FSM state encoding, the default
// reset PC and the controller ctrl bit indices.
package mips_pkg;

    localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

    // Instruction field bit positions
    localparam int unsigned OpcodeMsb = 31;
    localparam int unsigned OpcodeLsb = 26;
    localparam int unsigned RtMsb     = 20;
    localparam int unsigned RtLsb     = 16;
    localparam int unsigned FuncMsb   = 5;
    localparam int unsigned FuncLsb   = 0;
    localparam int unsigned ImmMsb    = 15;
    localparam int unsigned ImmLsb    = 0;
    localparam int unsigned JIdxMsb   = 25;
    localparam int unsigned JIdxLsb   = 0;

    // Controller ctrl vector bit indices
    localparam int unsigned CtrlJumpBit   = 1;
    localparam int unsigned CtrlBranchBit = 0;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StWait,
        StValid
    } fetch_state_e;

    // Sign-extended, word-scaled branch displacement.
    function automatic logic [31:0] branch_offset(logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel and the
// valid/ready channel to decode, plus decode's control inputs.
//   master : the fetch unit side
//   slave  : instruction memory + decode side
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [5:0]  func;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    logic        ctrl_jump;
    logic        ctrl_branch;
    logic        branch_cond;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        output instr_valid, instr, opcode, rt, func, pc, pc_plus4,
        input  instr_ready, ctrl_jump, ctrl_branch, branch_cond
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        input  instr_valid, instr, opcode, rt, func, pc, pc_plus4,
        output instr_ready, ctrl_jump, ctrl_branch, branch_cond
    );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection.
//   pc_plus4_i    : sequential PC of the current instruction
//   instr_i       : current instruction word
//   ctrl_jump_i   : J-type jump (priority over branch)
//   ctrl_branch_i : conditional branch
//   branch_cond_i : branch comparison result
//   next_pc_o     : PC of the next instruction to fetch
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] instr_i,
    input  logic        ctrl_jump_i,
    input  logic        ctrl_branch_i,
    input  logic        branch_cond_i,
    output logic [31:0] next_pc_o
);

    // Opcode bits are decoded upstream; not needed for target arithmetic.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_i[OpcodeMsb:OpcodeLsb];

    always_comb begin
        next_pc_o = pc_plus4_i;
        if (ctrl_jump_i) begin
            next_pc_o = {pc_plus4_i[31:28], instr_i[JIdxMsb:JIdxLsb], 2'b00};
        end else if (ctrl_branch_i && branch_cond_i) begin
            next_pc_o = pc_plus4_i + branch_offset(instr_i[ImmMsb:ImmLsb]);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Issues one instruction-memory read at a time from pc,
// latches the returned word and offers it to decode under valid/ready. On the
// decode handshake pc advances to the jump/branch/sequential target.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch_unit_if master (imem request/response, decode channel)
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DefaultResetPc
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    next_pc_calc u_next_pc_calc (
        .pc_plus4_i    (pc_plus4),
        .instr_i       (instr_q),
        .ctrl_jump_i   (bus.ctrl_jump),
        .ctrl_branch_i (bus.ctrl_branch),
        .branch_cond_i (bus.branch_cond),
        .next_pc_o     (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // rvalid only matters in StWait, so a stale response after reset is dropped.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (bus.imem_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.imem_rvalid) begin
                    instr_d = bus.imem_rdata;
                    state_d = StValid;
                end
            end
            StValid: begin
                if (bus.instr_ready) begin
                    pc_d    = next_pc;
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.imem_req    = (state_q == StFetch);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state_q == StValid);
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[OpcodeMsb:OpcodeLsb];
    assign bus.rt          = instr_q[RtMsb:RtLsb];
    assign bus.func        = instr_q[FuncMsb:FuncLsb];
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   acc_cnt;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts accepted memory requests on the main DUT.
    always @(posedge clk) begin
        if (bus.imem_req === 1'b1 && bus.imem_ready === 1'b1) acc_cnt <= acc_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From StFetch: accept at once, respond one cycle later.
    task automatic deliver(input logic [31:0] word);
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = word;
        step();
        bus.imem_rvalid = 1'b0;
    endtask

    task automatic consume(input logic j, input logic b, input logic c);
        bus.instr_ready = 1'b1;
        bus.ctrl_jump   = j;
        bus.ctrl_branch = b;
        bus.branch_cond = c;
        step();
        bus.instr_ready = 1'b0;
        bus.ctrl_jump   = 1'b0;
        bus.ctrl_branch = 1'b0;
        bus.branch_cond = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({bus.imem_req, bus.instr_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctl: got req/valid %b want 00", {bus.imem_req, bus.instr_valid});
        end
        checks++;
        if (bus.pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc: got %h want 00000000", bus.pc);
        end
        checks++;
        if (bus.instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_instr: got %h want 00000000", bus.instr);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_req: got %b want 0", bus.imem_req);
        end
        step();
        checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL first_req: got %b/%h want 1/00000000", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_sequential();
        deliver(32'h2008_0005);
        checks++;
        if ({bus.instr_valid, bus.instr} !== {1'b1, 32'h2008_0005}) begin
            errors++;
            $display("FAIL seq_instr: got %b/%h want 1/20080005", bus.instr_valid, bus.instr);
        end
        checks++;
        if ({bus.opcode, bus.rt, bus.func} !== {6'b001000, 5'b01000, 6'b000101}) begin
            errors++;
            $display("FAIL seq_fields: got %b %b %b want 001000 01000 000101",
                     bus.opcode, bus.rt, bus.func);
        end
        checks++;
        if ({bus.pc, bus.pc_plus4, bus.imem_req} !== {32'h0, 32'h4, 1'b0}) begin
            errors++;
            $display("FAIL seq_pc: got %h %h req %b want 00000000 00000004 0",
                     bus.pc, bus.pc_plus4, bus.imem_req);
        end
        consume(1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.instr_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h4}) begin
            errors++;
            $display("FAIL seq_next: got %b %b %h want 0 1 00000004",
                     bus.instr_valid, bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_jump();
        for (int i = 0; i < 3; i++) begin
            deliver(32'h0);
            consume(1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (bus.imem_addr !== 32'h10) begin
            errors++;
            $display("FAIL walk_addr: got %h want 00000010", bus.imem_addr);
        end
        deliver(32'h0800_0040);
        consume(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL jump_addr: got %h want 00000100", bus.imem_addr);
        end
        // Branch offset 0x40 would give 0x204; jump must win.
        deliver(32'h0800_0040);
        consume(1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL jump_prio: got %h want 00000100", bus.imem_addr);
        end
        deliver(32'h0800_0008);
        consume(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.imem_addr !== 32'h20) begin
            errors++;
            $display("FAIL jump_20: got %h want 00000020", bus.imem_addr);
        end
    endtask

    task automatic test_branch();
        deliver(32'h1000_FFFE);
        consume(1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.imem_addr !== 32'h1C) begin
            errors++;
            $display("FAIL br_taken: got %h want 0000001c", bus.imem_addr);
        end
        deliver(32'h0);
        consume(1'b0, 1'b0, 1'b0);
        deliver(32'h1000_FFFE);
        consume(1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.imem_addr !== 32'h24) begin
            errors++;
            $display("FAIL br_not_taken: got %h want 00000024", bus.imem_addr);
        end
    endtask

    task automatic test_stall();
        int base;
        base = acc_cnt;
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h24}) begin
                errors++;
                $display("FAIL stall_req: got %b/%h want 1/00000024", bus.imem_req, bus.imem_addr);
            end
        end
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({bus.imem_req, bus.instr_valid} !== 2'b00) begin
                errors++;
                $display("FAIL stall_wait: got req/valid %b want 00",
                         {bus.imem_req, bus.instr_valid});
            end
        end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h2009_0007;
        step();
        bus.imem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.ctrl_jump   = 1'b1;
            bus.ctrl_branch = 1'b1;
            bus.branch_cond = 1'b1;
            bus.imem_rvalid = (i == 1);
            bus.imem_rdata  = 32'hDEAD_BEEF;
            step();
            checks++;
            if ({bus.instr_valid, bus.imem_req, bus.instr, bus.pc} !==
                {1'b1, 1'b0, 32'h2009_0007, 32'h24}) begin
                errors++;
                $display("FAIL stall_hold: got %b %b %h %h want 1 0 20090007 00000024",
                         bus.instr_valid, bus.imem_req, bus.instr, bus.pc);
            end
        end
        bus.imem_rvalid = 1'b0;
        consume(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.imem_addr !== 32'h28) begin
            errors++;
            $display("FAIL stall_next: got %h want 00000028", bus.imem_addr);
        end
        checks++;
        if (acc_cnt - base !== 1) begin
            errors++;
            $display("FAIL stall_fetches: got %0d want 1", acc_cnt - base);
        end
    endtask

    task automatic test_reset_mid_wait();
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.imem_req, bus.instr_valid, bus.pc} !== {2'b00, 32'h0}) begin
            errors++;
            $display("FAIL async_rst: got %b %b %h want 0 0 00000000",
                     bus.imem_req, bus.instr_valid, bus.pc);
        end
        step();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        rst_n = 1'b1;
        step();
        checks++;
        if ({bus.instr_valid, bus.imem_req, bus.imem_addr, bus.instr} !==
            {1'b0, 1'b1, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL stale_idle: got %b %b %h %h want 0 1 00000000 00000000",
                     bus.instr_valid, bus.imem_req, bus.imem_addr, bus.instr);
        end
        // Still FETCH: stale rvalid and an early instr_ready must both be ignored.
        bus.instr_ready = 1'b1;
        bus.ctrl_jump   = 1'b1;
        step();
        checks++;
        if ({bus.instr_valid, bus.imem_req, bus.imem_addr, bus.instr} !==
            {1'b0, 1'b1, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL stale_fetch: got %b %b %h %h want 0 1 00000000 00000000",
                     bus.instr_valid, bus.imem_req, bus.imem_addr, bus.instr);
        end
        bus.imem_rvalid = 1'b0;
        bus.instr_ready = 1'b0;
        bus.ctrl_jump   = 1'b0;
        deliver(32'h2008_0005);
        checks++;
        if ({bus.instr_valid, bus.instr, bus.pc} !== {1'b1, 32'h2008_0005, 32'h0}) begin
            errors++;
            $display("FAIL refetch: got %b %h %h want 1 20080005 00000000",
                     bus.instr_valid, bus.instr, bus.pc);
        end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({bus2.imem_req, bus2.imem_addr, bus2.pc_plus4} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
            errors++;
            $display("FAIL wrap_start: got %b %h %h want 1 fffffffc 00000000",
                     bus2.imem_req, bus2.imem_addr, bus2.pc_plus4);
        end
        bus2.imem_ready = 1'b1;
        step();
        bus2.imem_ready  = 1'b0;
        bus2.imem_rvalid = 1'b1;
        bus2.imem_rdata  = 32'h0000_0000;
        step();
        bus2.imem_rvalid = 1'b0;
        bus2.instr_ready = 1'b1;
        step();
        bus2.instr_ready = 1'b0;
        checks++;
        if ({bus2.imem_req, bus2.imem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL wrap_next: got %b/%h want 1/00000000", bus2.imem_req, bus2.imem_addr);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        acc_cnt = 0;
        rst_n   = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.instr_ready = 1'b0;
        bus.ctrl_jump   = 1'b0;
        bus.ctrl_branch = 1'b0;
        bus.branch_cond = 1'b0;
        bus2.imem_ready  = 1'b0;
        bus2.imem_rvalid = 1'b0;
        bus2.imem_rdata  = 32'h0;
        bus2.instr_ready = 1'b0;
        bus2.ctrl_jump   = 1'b0;
        bus2.ctrl_branch = 1'b0;
        bus2.branch_cond = 1'b0;

        test_reset();
        test_sequential();
        test_jump();
        test_branch();
        test_stall();
        test_reset_mid_wait();
        test_wrap();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the MIPS processor, directly upstream of `controller`. Holds the PC and issues one instruction-memory read at a time. Latches the returned word into an instruction register and presents `opcode`/`func`/`rt` plus `pc`/`pc_plus4` to decode under a valid/ready handshake. Computes the next PC from the decoder's Jump/Branch control bits and the branch condition when decode accepts the instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000, first fetch address; bits [1:0] must be 0.
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  read request to instruction memory
- `imem_addr`  out  32  word-aligned fetch address, equals `pc`
- `imem_ready`  in  1  memory accepts request when `imem_req & imem_ready`
- `imem_rvalid`  in  1  read data valid, one pulse per accepted request
- `imem_rdata`  in  32  instruction word
- `instr_valid`  out  1  instruction register holds an undelivered instruction
- `instr_ready`  in  1  decode consumes when `instr_valid & instr_ready`
- `instr`  out  32  instruction register
- `opcode`  out  6  `instr[31:26]`
- `rt`  out  5  `instr[20:16]`
- `func`  out  6  `instr[5:0]`
- `pc`  out  32  address of `instr`
- `pc_plus4`  out  32  `pc + 4`, link value for jal
- `ctrl_jump`  in  1  controller ctrl[1], sampled at handshake
- `ctrl_branch`  in  1  controller ctrl[0], sampled at handshake
- `branch_cond`  in  1  branch comparison result from execute, sampled at handshake

## Operation
- States: IDLE, FETCH, WAIT, VALID.
- IDLE: entered on reset. Goes to FETCH on the next clock.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`. On `imem_ready`, go to WAIT.
- WAIT: `imem_req`=0. On `imem_rvalid`, capture `imem_rdata` into `instr` and go to VALID.
- VALID: `instr_valid`=1. `instr`, `pc` and the field outputs are held stable. On `instr_ready`:
  - load `pc` ← next_pc;
  - go to FETCH.
- next_pc:
  - if `ctrl_jump`: {pc_plus4[31:28], instr[25:0], 2'b00};
  - else if `ctrl_branch & branch_cond`: pc_plus4 + (sign_extend(instr[15:0]) << 2);
  - else: pc_plus4.
  - Jump has priority over branch.
- Arithmetic: 32-bit modulo. pc 32'hFFFF_FFFC + 4 wraps to 0. Bits [1:0] of `pc` are always 0.
- Control inputs are ignored outside the VALID handshake cycle.
- `imem_rvalid` is ignored in IDLE, FETCH and VALID. A stale response arriving after reset is discarded.
- Only one request is outstanding at a time. No redirect can arrive while a fetch is in flight.
- jr/jalr targets are out of scope for this block.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `instr`=0;
  - `instr_valid`=0, `imem_req`=0;
  - state IDLE.
- Reset asserted in any state returns to IDLE immediately and drops `imem_req` asynchronously.
- First `imem_req` is high in the 2nd rising edge after `rst_n` deasserts (one IDLE cycle).
- Memory request accepted at edge N → WAIT from N.
- `imem_rvalid` at edge M (M ≥ N+1) → `instr_valid`=1 from M.
- Decode handshake at edge K → `instr_valid`=0 and `imem_req`=1 with the new `pc` from K.
- Throughput with zero-wait memory and ready decode: 1 instruction per 3 cycles.
- `instr_ready` asserted while `instr_valid`=0 has no effect.
- `instr_valid` holds until consumed; decode back-pressure is unbounded.

## Structure
- Shared package `mips_pkg`:
  - opcode/func/rt field bit positions;
  - fetch state enum;
  - default `RESET_PC`;
  - ctrl bit indices (Jump=1, Branch=0), shared with `controller`.
- One combinational sub-module `next_pc_calc`: inputs `pc_plus4`, `instr`, `ctrl_jump`, `ctrl_branch`, `branch_cond`; output 32-bit next PC. FSM and registers stay in `fetch_unit`.

## Test plan
- Reset, `imem_ready`=1, rvalid next cycle with 32'h2008_0005 (addi), `instr_ready`=1, no jump/branch → `imem_addr` 0 then 4; `opcode`=001000, `rt`=01000.
- At pc=0x0000_0010, instr 32'h0800_0040 with `ctrl_jump`=1 → next `imem_addr`=0x0000_0100. `ctrl_jump`=1 and `ctrl_branch`=1 together → jump target wins.
- Branch:
  - at pc=0x0000_0020, offset 16'hFFFE, `ctrl_branch`=1, `branch_cond`=1 → next addr 0x0000_001C;
  - same with `branch_cond`=0 → 0x0000_0024.
- `imem_ready` low 3 cycles, then rvalid delayed 2 cycles, then `instr_ready` low 4 cycles → `imem_req` held with stable addr, `instr` and `pc` stable, exactly one fetch per instruction.
- Reset mid-WAIT, then a late `imem_rvalid` with 32'hDEAD_BEEF → ignored; refetch from `RESET_PC`; `instr_valid` stays 0 until the new response.
- `RESET_PC`=32'hFFFF_FFFC, sequential instruction consumed → next `imem_addr`=0.
